// File: rtl/accel_spi_sequencer.sv
// Accelerometer bring-up/sampling sequencer driving a byte-oriented SPI master: ID check, power config, periodic XYZ burst reads.
// Request outputs decode from registered state (dropped asynchronously by rst); sample/status outputs are registered one cycle after transaction done.
module accel_spi_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter logic [7:0]  DEVID_EXP     = 8'hE5,
    parameter logic [5:0]  PWR_ADDR      = 6'h2D,
    parameter logic [7:0]  PWR_VAL       = 8'h08,
    parameter logic [5:0]  DATA_ADDR     = 6'h32,
    parameter int unsigned TIMEOUT       = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               spi_cs,
    input  logic               spi_load,
    input  logic [15:0]        spi_rx,
    input  logic               spi_cmd_out,
    output logic               spi_start,
    output logic [7:0]         spi_cmd,
    output logic [3:0]         spi_n_wr,
    output logic [3:0]         spi_n_rd,
    output logic               spi_mb,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic               data_valid,
    output logic               id_ok,
    output logic               sample_err,
    output logic               error,
    output logic               busy,
    output logic [2:0]         state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CHECK_ID = 3'd1, S_CONFIG = 3'd2,
        S_WAIT_PERIOD = 3'd3, S_READ_XYZ = 3'd4, S_ERROR = 3'd5
    } state_e;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(SAMPLE_PERIOD + 2 * TIMEOUT + 2);

    state_e        st_q, st_d;
    logic          act_q, act_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] per_q, per_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    byte_q [6];
    logic [7:0]    byte_d [6];
    logic          load_q, cmdout_q, tog_q, tog_d, stop_q, stop_d;
    logic [15:0]   ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic          dv_q, dv_d, serr_q, serr_d, err_q, err_d, idok_q, idok_d;
    logic          in_spi, phase_exit, done, load_rise;
    logic          unused_rx;

    assign unused_rx = ^spi_rx[15:8];

    always_comb begin
        st_d = st_q; act_d = act_q; tmo_d = tmo_q; per_d = per_q;
        bcnt_d = bcnt_q; byte_d = byte_q; tog_d = tog_q; stop_d = stop_q;
        ax_d = ax_q; ay_d = ay_q; az_d = az_q;
        dv_d = 1'b0; serr_d = 1'b0; err_d = err_q; idok_d = idok_q;
        spi_start = 1'b0; spi_cmd = 8'h00; spi_n_wr = 4'd0; spi_n_rd = 4'd0; spi_mb = 1'b0;

        load_rise  = spi_load & ~load_q;
        in_spi     = st_q inside {S_CHECK_ID, S_CONFIG, S_READ_XYZ};
        phase_exit = act_q ? spi_cs : ~spi_cs;
        done       = in_spi & act_q & spi_cs;

        case (st_q)
            S_CHECK_ID: begin
                spi_cmd = 8'h80; spi_n_wr = 4'd1; spi_n_rd = 4'd1;
            end
            S_CONFIG: begin
                spi_cmd  = tog_q ? PWR_VAL : {2'b00, PWR_ADDR};
                spi_n_wr = 4'd2;
            end
            S_READ_XYZ: begin
                spi_cmd = {2'b11, DATA_ADDR}; spi_n_wr = 4'd1; spi_n_rd = 4'd6; spi_mb = 1'b1;
            end
            default: ;
        endcase

        if (in_spi) begin
            spi_start = ~act_q;
            tmo_d     = tmo_q + 1'b1;
            if (!enable) stop_d = 1'b1;
            if (st_q == S_CONFIG && spi_cmd_out != cmdout_q) tog_d = 1'b1;
            // Bytes beyond the sixth are dropped; slot index doubles as the count.
            if (act_q && load_rise && bcnt_q != 3'd6) begin
                for (int i = 0; i < 6; i++)
                    if (bcnt_q == 3'(i)) byte_d[i] = spi_rx[7:0];
                bcnt_d = bcnt_q + 3'd1;
            end
            if (st_q == S_READ_XYZ) per_d = per_q + 1'b1;

            if (!phase_exit && tmo_q == TW'(TIMEOUT - 1)) begin
                st_d = S_ERROR; err_d = 1'b1; act_d = 1'b0;
            end else if (!act_q && !spi_cs) begin
                act_d = 1'b1; tmo_d = '0;
            end else if (done) begin
                act_d = 1'b0; tmo_d = '0; tog_d = 1'b0;
                case (st_q)
                    S_CHECK_ID: begin
                        if (bcnt_d != 3'd0 && byte_d[0] == DEVID_EXP) begin
                            idok_d = 1'b1;
                            st_d   = stop_d ? S_IDLE : S_CONFIG;
                        end else begin
                            err_d = 1'b1; st_d = S_ERROR;
                        end
                    end
                    S_CONFIG: begin
                        per_d = '0;
                        st_d  = stop_d ? S_IDLE : S_WAIT_PERIOD;
                    end
                    default: begin
                        if (bcnt_d == 3'd6) begin
                            ax_d = {byte_d[1], byte_d[0]};
                            ay_d = {byte_d[3], byte_d[2]};
                            az_d = {byte_d[5], byte_d[4]};
                            dv_d = 1'b1;
                        end else begin
                            serr_d = 1'b1;
                        end
                        st_d = stop_d ? S_IDLE : S_WAIT_PERIOD;
                    end
                endcase
            end
        end

        case (st_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (enable) begin
                    st_d = S_CHECK_ID; err_d = 1'b0; idok_d = 1'b0;
                    act_d = 1'b0; tmo_d = '0; bcnt_d = '0; tog_d = 1'b0;
                end
            end
            S_WAIT_PERIOD: begin
                if (!enable) begin
                    st_d = S_IDLE;
                end else if (per_q >= PW'(SAMPLE_PERIOD - 1)) begin
                    // Period restarts here so spacing is measured start-to-start.
                    st_d = S_READ_XYZ; per_d = '0;
                    act_d = 1'b0; tmo_d = '0; bcnt_d = '0;
                end else begin
                    per_d = per_q + 1'b1;
                end
            end
            S_ERROR: if (!enable) st_d = S_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= S_IDLE; act_q <= 1'b0; tmo_q <= '0; per_q <= '0; bcnt_q <= '0;
            for (int i = 0; i < 6; i++) byte_q[i] <= 8'h00;
            load_q <= 1'b0; cmdout_q <= 1'b0; tog_q <= 1'b0; stop_q <= 1'b0;
            ax_q <= '0; ay_q <= '0; az_q <= '0;
            dv_q <= 1'b0; serr_q <= 1'b0; err_q <= 1'b0; idok_q <= 1'b0;
        end else begin
            st_q <= st_d; act_q <= act_d; tmo_q <= tmo_d; per_q <= per_d; bcnt_q <= bcnt_d;
            byte_q <= byte_d;
            load_q <= spi_load; cmdout_q <= spi_cmd_out; tog_q <= tog_d; stop_q <= stop_d;
            ax_q <= ax_d; ay_q <= ay_d; az_q <= az_d;
            dv_q <= dv_d; serr_q <= serr_d; err_q <= err_d; idok_q <= idok_d;
        end
    end

    assign accel_x    = ax_q;
    assign accel_y    = ay_q;
    assign accel_z    = az_q;
    assign data_valid = dv_q;
    assign sample_err = serr_q;
    assign error      = err_q;
    assign id_ok      = idok_q;
    assign busy       = (st_q != S_IDLE);
    assign state      = st_q;
endmodule
